minisys_id_stage: RTL and testbench
===================================

Name: minisys_id_stage

Overview:
Instruction-decode stage of the Minisys-1A five-stage pipeline. It sits directly downstream of the fetch stage and consumes its instrD/pcplus4D registers. It contains the 32x32 register file, the main decoder, immediate extension and load-use hazard detection. It produces the registered ID/EX pipeline bundle for the execute stage.

Parameters:
- ALUC_W, 4, width of the ALU control code.
- RESET_PC4, 32'h0000_0004, reset value of pcplus4E.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- instrD  in  32  instruction from the IF/ID register
- pcplus4D  in  32  PC+4 from the IF/ID register
- regwriteW  in  1  writeback enable
- writeregW  in  5  writeback destination
- resultW  in  32  writeback data
- flushE  in  1  squash the ID/EX contents (branch taken in M)
- stallD  out  1  load-use stall, combinational, to IF (hold PC and IF/ID)
- regwriteE, memtoregE, memwriteE, branchE, bneE, alusrcE  out  1 each  registered control
- aluctrlE  out  ALUC_W  registered ALU operation
- rd1E, rd2E  out  32  registered register-file read data
- immE  out  32  registered extended immediate
- shamtE  out  5  registered shift amount
- rsE, rtE  out  5  registered source indices (for forwarding)
- writeregE  out  5  registered destination (rd or rt, already selected)
- pcplus4E  out  32  registered PC+4

Behaviour:
Register file
- r0 always reads 0. Writes to r0 are ignored.
- Write occurs on the clk edge when regwriteW=1.
- The two read ports are combinational on instrD[25:21] and instrD[20:16].
- Write-through: a read of a register being written in the same cycle returns resultW (writeregW!=0).
- clr does not clear register contents.

Decoder
- R-type (op=0): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra.
- I-type: addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne.
- Any other op or funct decodes to all-control-zero (NOP bundle).
- aluctrl codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
- lw and sw use ADD. beq and bne use SUB with branchE=1; bneE=1 for bne only.
- writereg = rd for R-type, rt for I-type. regwrite=0 for sw, beq, bne and NOP.
- alusrc=1 for all I-type except beq and bne.
- Immediate extension: zero-extend for andi, ori, xori; sign-extend otherwise. lui passes imm unshifted; EX performs <<16.

Hazard unit
- usesRs is 1 for every valid instruction except sll, srl, sra and lui.
- usesRt is 1 for R-type, sw, beq and bne.
- stallD = memtoregE & (writeregE!=0) & ((usesRs & rsD==writeregE) | (usesRt & rtD==writeregE)).
- The hazard check uses the currently registered E outputs.

ID/EX register (priority order)
1. clr: all control outputs 0, all data outputs 0, pcplus4E=RESET_PC4.
2. flushE: control outputs 0 (bubble). Data fields don't-care but are cleared to 0.
3. stallD: insert a bubble exactly as flushE. The same instruction re-decodes next cycle.
4. Otherwise: load the decoded bundle.
- Latency: an instruction in D at cycle n appears on the E outputs after edge n+1.
- flushE and stallD together: treated as a bubble; stallD is still driven to IF.
- A stall lasts exactly one cycle, because the bubble clears memtoregE.
- Reset mid-stall: stallD falls in the cycle after clr, since memtoregE=0.

Test Plan:
- Reset: assert clr for 2 cycles -> all E control 0, rd1E=0, pcplus4E=32'h4, stallD=0.
- addi: instrD=addi $1,$0,-5 (0x2001FFFB) -> next cycle regwriteE=1, alusrcE=1, aluctrlE=0, immE=0xFFFFFFFB, writeregE=1.
- ori zero-extension: ori $2,$0,0x8000 -> immE=0x00008000.
- Write-through: regwriteW=1, writeregW=3, resultW=0x1234 while instrD=add $4,$3,$3 -> rd1E=rd2E=0x1234 after the edge.
- r0 protection: write 0xFFFF to r0, then read r0 -> 0.
- Load-use: lw $5,0($0) followed by add $6,$5,$0 -> stallD=1 for one cycle, one bubble (regwriteE=0), then the add issues with rsE=5; the same sequence with sll $6,$5,2 using rt=5 also stalls, while lui $5,1 after the lw does not stall.
- flushE: flushE=1 with valid instrD -> all E control 0 next cycle.

Source files
------------

// File: rtl/minisys_id_stage_if.sv
// Minisys-1A decode-stage bus: the IF/ID inputs, the writeback return path,
// the flush/stall handshake, and the registered ID/EX bundle for execute.
interface minisys_id_stage_if #(
  parameter int ALUC_W = 4
);
  logic [31:0]       instrD;
  logic [31:0]       pcplus4D;
  logic              regwriteW;
  logic [4:0]        writeregW;
  logic [31:0]       resultW;
  logic              flushE;
  logic              stallD;
  logic              regwriteE;
  logic              memtoregE;
  logic              memwriteE;
  logic              branchE;
  logic              bneE;
  logic              alusrcE;
  logic [ALUC_W-1:0] aluctrlE;
  logic [31:0]       rd1E;
  logic [31:0]       rd2E;
  logic [31:0]       immE;
  logic [4:0]        shamtE;
  logic [4:0]        rsE;
  logic [4:0]        rtE;
  logic [4:0]        writeregE;
  logic [31:0]       pcplus4E;

  // The pipeline around the stage (fetch, writeback, execute) drives this side
  modport master (
    output instrD, pcplus4D, regwriteW, writeregW, resultW, flushE,
    input  stallD, regwriteE, memtoregE, memwriteE, branchE, bneE, alusrcE,
    input  aluctrlE, rd1E, rd2E, immE, shamtE, rsE, rtE, writeregE, pcplus4E
  );

  // The decode stage itself
  modport slave (
    input  instrD, pcplus4D, regwriteW, writeregW, resultW, flushE,
    output stallD, regwriteE, memtoregE, memwriteE, branchE, bneE, alusrcE,
    output aluctrlE, rd1E, rd2E, immE, shamtE, rsE, rtE, writeregE, pcplus4E
  );
endinterface

// File: rtl/minisys_id_stage.sv
// Minisys-1A instruction-decode stage: register file with write-through,
// main decoder, immediate extension, load-use hazard detection and the
// ID/EX pipeline register.
module minisys_id_stage #(
  parameter int          ALUC_W    = 4,
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
  input logic               clk,
  input logic               clr,
  minisys_id_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              branch;
    logic              bne;
    logic              alusrc;
    logic [ALUC_W-1:0] aluctrl;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       imm;
    logic [4:0]        shamt;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        writereg;
    logic [31:0]       pcplus4;
  } idex_t;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign op    = bus.instrD[31:26];
  assign rs    = bus.instrD[25:21];
  assign rt    = bus.instrD[20:16];
  assign rd    = bus.instrD[15:11];
  assign shamt = bus.instrD[10:6];
  assign funct = bus.instrD[5:0];
  assign imm16 = bus.instrD[15:0];

  logic [31:0] regs [32];
  logic [31:0] rd1;
  logic [31:0] rd2;

  // Register file write port; r0 is never written so it stays architecturally zero
  always_ff @(posedge clk) begin
    if (bus.regwriteW && (bus.writeregW != 5'd0)) begin
      regs[bus.writeregW] <= bus.resultW;
    end
  end

  // Combinational read ports with write-through from the writeback stage
  always_comb begin
    rd1 = 32'd0;
    rd2 = 32'd0;
    if (rs != 5'd0) begin
      if (bus.regwriteW && (bus.writeregW == rs)) rd1 = bus.resultW;
      else                                        rd1 = regs[rs];
    end
    if (rt != 5'd0) begin
      if (bus.regwriteW && (bus.writeregW == rt)) rd2 = bus.resultW;
      else                                        rd2 = regs[rt];
    end
  end

  logic    valid;
  logic    dec_regwrite;
  logic    dec_memtoreg;
  logic    dec_memwrite;
  logic    dec_branch;
  logic    dec_bne;
  logic    dec_alusrc;
  logic    sel_rd;
  logic    zero_ext;
  logic    uses_rs;
  logic    uses_rt;
  alu_op_e alu_op;

  // Main decoder; unrecognised opcodes or functs fall back to an all-zero control bundle
  always_comb begin
    valid        = 1'b0;
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    dec_bne      = 1'b0;
    dec_alusrc   = 1'b0;
    sel_rd       = 1'b0;
    zero_ext     = 1'b0;
    uses_rs      = 1'b0;
    uses_rt      = 1'b0;
    alu_op       = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        valid        = 1'b1;
        dec_regwrite = 1'b1;
        sel_rd       = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL: begin alu_op = ALU_SLL; uses_rs = 1'b0; end
          FN_SRL: begin alu_op = ALU_SRL; uses_rs = 1'b0; end
          FN_SRA: begin alu_op = ALU_SRA; uses_rs = 1'b0; end
          default: begin
            valid        = 1'b0;
            dec_regwrite = 1'b0;
            sel_rd       = 1'b0;
            uses_rs      = 1'b0;
            uses_rt      = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        valid        = 1'b1;
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        uses_rs      = (op != OP_LUI);
        dec_memtoreg = (op == OP_LW);
        zero_ext     = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        case (op)
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: alu_op = ALU_SLTU;
          OP_ANDI:  alu_op = ALU_AND;
          OP_ORI:   alu_op = ALU_OR;
          OP_XORI:  alu_op = ALU_XOR;
          OP_LUI:   alu_op = ALU_LUI;
          default:  alu_op = ALU_ADD;
        endcase
      end
      OP_SW: begin
        valid        = 1'b1;
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
        alu_op       = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        valid      = 1'b1;
        dec_branch = 1'b1;
        dec_bne    = (op == OP_BNE);
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
        alu_op     = ALU_SUB;
      end
      default: begin
        valid = 1'b0;
      end
    endcase
  end

  idex_t dec;
  idex_t idex;
  logic  stall;

  // Assemble the decoded bundle that the ID/EX register loads on a normal cycle
  always_comb begin
    dec          = '0;
    dec.regwrite = dec_regwrite;
    dec.memtoreg = dec_memtoreg;
    dec.memwrite = dec_memwrite;
    dec.branch   = dec_branch;
    dec.bne      = dec_bne;
    dec.alusrc   = dec_alusrc;
    dec.aluctrl  = ALUC_W'(alu_op);
    dec.rd1      = rd1;
    dec.rd2      = rd2;
    dec.imm      = zero_ext ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};
    dec.shamt    = shamt;
    dec.rs       = rs;
    dec.rt       = rt;
    dec.writereg = valid ? (sel_rd ? rd : rt) : 5'd0;
    dec.pcplus4  = bus.pcplus4D;
  end

  // Load-use hazard against the load currently sitting in execute
  always_comb begin
    stall = 1'b0;
    if (idex.memtoreg && (idex.writereg != 5'd0)) begin
      stall = (uses_rs && (rs == idex.writereg)) || (uses_rt && (rt == idex.writereg));
    end
  end

  assign bus.stallD = stall;

  // ID/EX register: reset beats bubble (flush or stall) beats a normal load
  always_ff @(posedge clk) begin
    if (clr) begin
      idex         <= '0;
      idex.pcplus4 <= RESET_PC4;
    end else if (bus.flushE || stall) begin
      idex <= '0;
    end else begin
      idex <= dec;
    end
  end

  assign bus.regwriteE = idex.regwrite;
  assign bus.memtoregE = idex.memtoreg;
  assign bus.memwriteE = idex.memwrite;
  assign bus.branchE   = idex.branch;
  assign bus.bneE      = idex.bne;
  assign bus.alusrcE   = idex.alusrc;
  assign bus.aluctrlE  = idex.aluctrl;
  assign bus.rd1E      = idex.rd1;
  assign bus.rd2E      = idex.rd2;
  assign bus.immE      = idex.imm;
  assign bus.shamtE    = idex.shamt;
  assign bus.rsE       = idex.rs;
  assign bus.rtE       = idex.rt;
  assign bus.writeregE = idex.writereg;
  assign bus.pcplus4E  = idex.pcplus4;

endmodule

// File: tb/tb_minisys_id_stage.sv
// Self-checking bench for minisys_id_stage: directed scenarios followed by
// randomized instruction streams, checked against a table-driven ISA model.
module tb_minisys_id_stage;

  localparam int          ALUC_W    = 4;
  localparam logic [31:0] RESET_PC4 = 32'h0000_0004;
  localparam int          NTAB      = 25;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  minisys_id_stage_if #(.ALUC_W(ALUC_W)) bus ();

  minisys_id_stage #(.ALUC_W(ALUC_W), .RESET_PC4(RESET_PC4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  // Instruction table: opcode, funct (R-type only), ALU code, kind.
  // kind: 0 R-alu, 1 R-shift, 2 I-alu signed imm, 3 I-logic zero-ext imm,
  //       4 lui, 5 lw, 6 sw, 7 beq, 8 bne
  int tab_op   [NTAB] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          8, 9, 10, 11, 12, 13, 14, 15, 35, 43, 4, 5};
  int tab_fn   [NTAB] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int tab_alu  [NTAB] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10,
                          0, 0, 6, 7, 2, 3, 4, 11, 0, 0, 1, 1};
  int tab_kind [NTAB] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,
                          2, 2, 2, 2, 3, 3, 3, 4, 5, 6, 7, 8};

  typedef struct {
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        branch;
    logic        bne;
    logic        alusrc;
    logic [3:0]  aluc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [31:0] pc4;
    bit          valid;
  } ebun_t;

  ebun_t       model_e;
  logic [31:0] model_rf [32];

  function automatic int classify(input logic [31:0] ins);
    for (int i = 0; i < NTAB; i++) begin
      if (int'(ins[31:26]) == tab_op[i] && (tab_op[i] != 0 || int'(ins[5:0]) == tab_fn[i]))
        return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] read_model(input logic [4:0] idx, input logic rw,
                                             input logic [4:0] wr, input logic [31:0] res);
    if (idx == 5'd0) return 32'd0;
    if (rw && wr == idx) return res;
    return model_rf[idx];
  endfunction

  function automatic ebun_t bubble_bundle();
    ebun_t b;
    b.regwrite = 0; b.memtoreg = 0; b.memwrite = 0; b.branch = 0; b.bne = 0; b.alusrc = 0;
    b.aluc = 4'd0; b.rd1 = 32'd0; b.rd2 = 32'd0; b.imm = 32'd0; b.shamt = 5'd0;
    b.rs = 5'd0; b.rt = 5'd0; b.wreg = 5'd0; b.pc4 = 32'd0; b.valid = 1'b1;
    return b;
  endfunction

  function automatic ebun_t decode_model(input logic [31:0] ins, input logic [31:0] pc4,
                                         input logic rw, input logic [4:0] wr,
                                         input logic [31:0] res);
    ebun_t b;
    int    idx;
    int    k;
    b     = bubble_bundle();
    idx   = classify(ins);
    k     = (idx >= 0) ? tab_kind[idx] : -1;
    b.rs    = ins[25:21];
    b.rt    = ins[20:16];
    b.shamt = ins[10:6];
    b.rd1   = read_model(ins[25:21], rw, wr, res);
    b.rd2   = read_model(ins[20:16], rw, wr, res);
    b.imm   = (k == 3) ? {16'd0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    b.pc4   = pc4;
    b.valid = (idx >= 0);
    if (idx >= 0) begin
      b.regwrite = !(k == 6 || k == 7 || k == 8);
      b.memtoreg = (k == 5);
      b.memwrite = (k == 6);
      b.branch   = (k == 7 || k == 8);
      b.bne      = (k == 8);
      b.alusrc   = (k >= 2 && k <= 6);
      b.aluc     = 4'(tab_alu[idx]);
      b.wreg     = (k <= 1) ? ins[15:11] : ins[20:16];
    end
    return b;
  endfunction

  function automatic logic stall_model(input logic [31:0] ins);
    int idx;
    int k;
    bit urs;
    bit urt;
    idx = classify(ins);
    if (idx < 0) return 1'b0;
    k   = tab_kind[idx];
    urs = !(k == 1 || k == 4);
    urt = (k <= 1) || (k >= 6);
    return model_e.memtoreg && (model_e.wreg != 5'd0) &&
           ((urs && ins[25:21] == model_e.wreg) || (urt && ins[20:16] == model_e.wreg));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("regwriteE", 32'(bus.regwriteE), 32'(model_e.regwrite));
    chk("memtoregE", 32'(bus.memtoregE), 32'(model_e.memtoreg));
    chk("memwriteE", 32'(bus.memwriteE), 32'(model_e.memwrite));
    chk("branchE",   32'(bus.branchE),   32'(model_e.branch));
    chk("bneE",      32'(bus.bneE),      32'(model_e.bne));
    chk("alusrcE",   32'(bus.alusrcE),   32'(model_e.alusrc));
    chk("aluctrlE",  32'(bus.aluctrlE),  32'(model_e.aluc));
    chk("rd1E",      bus.rd1E,           model_e.rd1);
    chk("rd2E",      bus.rd2E,           model_e.rd2);
    chk("immE",      bus.immE,           model_e.imm);
    chk("shamtE",    32'(bus.shamtE),    32'(model_e.shamt));
    chk("rsE",       32'(bus.rsE),       32'(model_e.rs));
    chk("rtE",       32'(bus.rtE),       32'(model_e.rt));
    if (model_e.valid) chk("writeregE", 32'(bus.writeregE), 32'(model_e.wreg));
    chk("pcplus4E",  bus.pcplus4E,       model_e.pc4);
  endtask

  logic last_stall;

  // One pipeline cycle: drive D/W inputs, check the combinational stall, clock, check E
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc4,
                               input logic rw, input logic [4:0] wr, input logic [31:0] res,
                               input logic flush, input logic rst);
    ebun_t nxt;
    logic  exp_stall;
    bus.instrD    = ins;
    bus.pcplus4D  = pc4;
    bus.regwriteW = rw;
    bus.writeregW = wr;
    bus.resultW   = res;
    bus.flushE    = flush;
    clr           = rst;
    #2;
    exp_stall = stall_model(ins);
    chk("stallD", 32'(bus.stallD), 32'(exp_stall));
    last_stall = exp_stall;
    if (rst) begin
      nxt     = bubble_bundle();
      nxt.pc4 = RESET_PC4;
    end else if (flush || exp_stall) begin
      nxt = bubble_bundle();
    end else begin
      nxt = decode_model(ins, pc4, rw, wr, res);
    end
    @(posedge clk);
    if (rw && wr != 5'd0) model_rf[wr] = res;
    model_e = nxt;
    #1;
    checkOutput();
  endtask

  function automatic logic [31:0] gen_instr();
    int          r;
    int          idx;
    logic [31:0] ins;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    rs_f = 5'($urandom_range(0, 7));
    rt_f = 5'($urandom_range(0, 7));
    rd_f = 5'($urandom_range(0, 7));
    r    = $urandom_range(0, 99);
    if (r >= 92) begin
      if (r[0]) ins = {6'h00, rs_f, rt_f, rd_f, 5'($urandom), 6'h3F};
      else      ins = {(r[1] ? 6'h3F : 6'h01), rs_f, rt_f, 16'($urandom)};
      return ins;
    end
    idx = (r < 25) ? 21 : $urandom_range(0, NTAB - 1);
    if (tab_op[idx] == 0)
      ins = {6'h00, rs_f, rt_f, rd_f, 5'($urandom), 6'(tab_fn[idx])};
    else
      ins = {6'(tab_op[idx]), rs_f, rt_f, 16'($urandom)};
    return ins;
  endfunction

  initial begin
    logic [31:0] ins;
    logic [31:0] cur;
    bus.instrD    = 32'd0;
    bus.pcplus4D  = 32'd0;
    bus.regwriteW = 1'b0;
    bus.writeregW = 5'd0;
    bus.resultW   = 32'd0;
    bus.flushE    = 1'b0;
    clr           = 1'b1;
    last_stall    = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    @(posedge clk);
    #1;
    model_e     = bubble_bundle();
    model_e.pc4 = RESET_PC4;

    $display("[TB] reset and register-file preload");
    for (int i = 1; i < 32; i++)
      applyStimulus(32'd0, 32'h100, 1'b1, 5'(i), $urandom, 1'b0, 1'b1);
    applyStimulus(32'd0, 32'h100, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 1'b1);
    chk("reset_pcplus4E", bus.pcplus4E, 32'h4);
    chk("reset_rd1E", bus.rd1E, 32'd0);

    $display("[TB] directed decode cases");
    applyStimulus(32'h2001_FFFB, 32'h104, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("addi_imm", bus.immE, 32'hFFFF_FFFB);
    chk("addi_wreg", 32'(bus.writeregE), 32'd1);
    applyStimulus(32'h3402_8000, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("ori_imm", bus.immE, 32'h0000_8000);
    applyStimulus(32'h0063_2020, 32'h10C, 1'b1, 5'd3, 32'h1234, 1'b0, 1'b0);
    chk("wt_rd1", bus.rd1E, 32'h1234);
    chk("wt_rd2", bus.rd2E, 32'h1234);
    applyStimulus(32'd0, 32'h110, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0);
    applyStimulus(32'h0000_0820, 32'h114, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("r0_read", bus.rd1E, 32'd0);

    $display("[TB] load-use hazards");
    applyStimulus(32'h8C05_0000, 32'h118, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h00A0_3020, 32'h11C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("lu_stall_bubble", 32'(bus.regwriteE), 32'd0);
    applyStimulus(32'h00A0_3020, 32'h11C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("lu_add_rsE", 32'(bus.rsE), 32'd5);
    applyStimulus(32'h8C05_0000, 32'h120, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h0005_3080, 32'h124, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h0005_3080, 32'h124, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h8C05_0000, 32'h128, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h3C05_0001, 32'h12C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("lui_no_stall", 32'(bus.aluctrlE), 32'd11);

    $display("[TB] flush, flush with stall, reset mid-stall");
    applyStimulus(32'h2001_FFFB, 32'h130, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(32'h8C05_0000, 32'h134, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h00A0_3020, 32'h138, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(32'h8C05_0000, 32'h13C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h00A0_3020, 32'h140, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(32'h00A0_3020, 32'h140, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    $display("[TB] randomized instruction stream");
    cur = gen_instr();
    for (int n = 0; n < 500; n++) begin
      if (!last_stall) cur = gen_instr();
      ins = cur;
      applyStimulus(ins, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
